// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one byte read at a time to a byte-wide
// instruction memory, assembles INST_W_BYTES bytes little-endian into one word
// and hands it to the decoder with a valid/ready handshake. A redirect flushes
// any partial fetch and drains an in-flight memory response.
module fetch_sequencer #(
    parameter int I_ADDR_W     = 12,
    parameter int INST_W_BYTES = 2,
    parameter int DATA_W       = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           fetch_en,
    input  logic [I_ADDR_W-1:0]            pc,
    input  logic                           redirect,
    output logic                           pc_advance,
    output logic                           mem_req,
    output logic [I_ADDR_W-1:0]            mem_addr,
    input  logic                           mem_gnt,
    input  logic                           mem_rvalid,
    input  logic [DATA_W-1:0]              mem_rdata,
    output logic                           inst_valid,
    input  logic                           inst_ready,
    output logic [INST_W_BYTES*DATA_W-1:0] inst_data,
    output logic [I_ADDR_W-1:0]            inst_pc,
    output logic                           busy
);

    localparam int BW = (INST_W_BYTES > 1) ? $clog2(INST_W_BYTES) : 1;
    localparam logic [BW-1:0]       LAST_IDX    = BW'(INST_W_BYTES - 1);
    localparam logic [I_ADDR_W-1:0] INST_STRIDE = I_ADDR_W'(INST_W_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DELIVER,
        DRAIN
    } state_t;

    state_t          state;
    logic [BW-1:0]   byte_idx;

    // Fetch state machine: request sequencing, byte assembly, redirect flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            byte_idx  <= '0;
            inst_data <= '0;
            inst_pc   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fetch_en) begin
                        state    <= ISSUE;
                        byte_idx <= '0;
                        inst_pc  <= pc;
                    end
                end
                ISSUE: begin
                    // While requesting byte 0 inst_pc follows pc, so a redirect
                    // here is picked up on the following cycle without extra state.
                    if (byte_idx == '0)
                        inst_pc <= pc;
                    if (redirect) begin
                        byte_idx <= '0;
                        if (mem_gnt)
                            state <= DRAIN;
                    end else if (mem_gnt) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        byte_idx <= '0;
                        state    <= mem_rvalid ? ISSUE : DRAIN;
                    end else if (mem_rvalid) begin
                        inst_data[int'(byte_idx)*DATA_W +: DATA_W] <= mem_rdata;
                        if (byte_idx == LAST_IDX) begin
                            state <= DELIVER;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= ISSUE;
                        end
                    end
                end
                DELIVER: begin
                    // A redirect consumes the word without advancing the PC.
                    if (redirect || inst_ready) begin
                        byte_idx <= '0;
                        if (fetch_en) begin
                            state   <= ISSUE;
                            inst_pc <= redirect ? pc : pc + INST_STRIDE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (mem_rvalid) begin
                        byte_idx <= '0;
                        if (fetch_en) begin
                            state   <= ISSUE;
                            inst_pc <= pc;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode straight from the state register
    always_comb begin
        mem_req    = (state == ISSUE);
        mem_addr   = mem_req ? pc + {{(I_ADDR_W-BW){1'b0}}, byte_idx} : '0;
        inst_valid = (state == DELIVER);
        pc_advance = inst_valid && inst_ready && !redirect;
        busy       = (state != IDLE);
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: memory responder, PC register and decoder are
// emulated here; a transaction-level model predicts every output each cycle.
module tb_fetch_sequencer;

    localparam int AW = 12;
    localparam int NB = 2;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_en;
    logic [AW-1:0]     pc;
    logic              redirect;
    logic              pc_advance;
    logic              mem_req;
    logic [AW-1:0]     mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DW-1:0]     mem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [NB*DW-1:0]  inst_data;
    logic [AW-1:0]     inst_pc;
    logic              busy;

    fetch_sequencer #(.I_ADDR_W(AW), .INST_W_BYTES(NB), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc(pc), .redirect(redirect),
        .pc_advance(pc_advance), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_pc(inst_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    // stimulus knobs
    int unsigned gnt_pct, rdy_pct, lat_min, lat_max;
    logic        en_knob;
    logic        redir_now;
    logic [AW-1:0] redir_tgt;

    // environment: PC register, memory image, single-outstanding responder
    logic [AW-1:0] pc_r;
    logic [7:0]    mem [4096];
    int unsigned   resp_cnt;
    logic [AW-1:0] resp_addr;

    // model: is a fetch active, bytes collected, response pending, response to drop
    logic          m_act, m_pend, m_flush;
    int unsigned   m_have;
    logic [AW-1:0] m_base;
    logic [7:0]    m_word [NB];

    // last observed DUT outputs, for directed literal checks
    logic          obs_req, obs_val, obs_adv, obs_busy;
    logic [AW-1:0] obs_addr, obs_pc;
    logic [NB*DW-1:0] obs_data;
    logic [AW-1:0] req_log [$];
    int            cyc, first_req, val_cyc;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_act = 1'b0; m_pend = 1'b0; m_flush = 1'b0; m_have = 0; m_base = '0;
    endtask

    // Entered and left at posedge+1
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_data", inst_data, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_pc_advance", pc_advance, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One clock: drive inputs, compare at negedge, advance model and environment
    task automatic cycle();
        logic e_req, e_val, e_adv, e_busy;
        logic [AW-1:0] e_addr;
        logic [NB*DW-1:0] e_data;
        redirect = 1'b0;
        if (redir_now && !(m_pend && m_flush && resp_cnt == 1)) begin
            redirect = 1'b1;
            pc_r = redir_tgt;
        end
        redir_now  = 1'b0;
        pc         = pc_r;
        fetch_en   = en_knob;
        e_busy     = m_act;
        e_req      = m_act && (m_have < NB) && !m_pend;
        e_addr     = e_req ? pc_r + AW'(m_have) : '0;
        e_val      = m_act && (m_have == NB);
        inst_ready = ($urandom_range(99) < rdy_pct);
        mem_gnt    = e_req && (resp_cnt == 0) && ($urandom_range(99) < gnt_pct);
        mem_rvalid = (resp_cnt == 1);
        mem_rdata  = mem_rvalid ? mem[resp_addr] : 8'($urandom);
        e_adv      = e_val && inst_ready && !redirect;
        for (int b = 0; b < NB; b++) e_data[b*DW +: DW] = m_word[b];

        @(negedge clk);
        obs_req = mem_req; obs_addr = mem_addr; obs_val = inst_valid; obs_adv = pc_advance;
        obs_busy = busy; obs_data = inst_data; obs_pc = inst_pc;
        if (obs_req) begin
            if (req_log.size() == 0 || req_log[$] != obs_addr || first_req < 0) req_log.push_back(obs_addr);
            if (first_req < 0) first_req = cyc;
        end
        if (obs_val) val_cyc = cyc;
        chk("busy", busy, e_busy);
        chk("mem_req", mem_req, e_req);
        chk("mem_addr", mem_addr, e_addr);
        chk("inst_valid", inst_valid, e_val);
        chk("pc_advance", pc_advance, e_adv);
        if (e_val) begin
            chk("inst_data", inst_data, e_data);
            chk("inst_pc", inst_pc, m_base);
        end

        if (!m_act) begin
            if (fetch_en) begin m_act = 1'b1; m_have = 0; end
        end else if (m_have == NB) begin
            if (redirect || inst_ready) begin
                if (fetch_en) m_have = 0;
                else m_act = 1'b0;
            end
        end else if (m_pend) begin
            if (mem_rvalid) begin
                m_pend = 1'b0;
                if (m_flush) begin
                    m_flush = 1'b0; m_have = 0;
                    if (!fetch_en) m_act = 1'b0;
                end else if (redirect) begin
                    m_have = 0;
                end else begin
                    m_word[m_have] = mem_rdata;
                    m_have++;
                end
            end else if (redirect) begin
                m_flush = 1'b1; m_have = 0;
            end
        end else begin
            if (mem_gnt) begin
                m_pend = 1'b1;
                if (m_have == 0) m_base = pc_r;
                if (redirect) begin m_flush = 1'b1; m_have = 0; end
            end else if (redirect) begin
                m_have = 0;
            end
        end

        @(posedge clk); #1;
        if (e_adv) pc_r = pc_r + AW'(NB);
        if (mem_gnt) begin
            resp_cnt  = $urandom_range(lat_max, lat_min);
            resp_addr = e_addr;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
        end
        cyc++;
    endtask

    task automatic run_until_valid(input int maxc);
        int n = 0;
        do begin cycle(); n++; end while (!obs_val && n < maxc);
        chk("valid_timeout", obs_val, 1);
    endtask

    task automatic start_test(input logic [AW-1:0] start_pc);
        do_reset();
        pc_r = start_pc; en_knob = 1'b1; gnt_pct = 100; rdy_pct = 100;
        lat_min = 1; lat_max = 1;
        req_log.delete(); first_req = -1; val_cyc = -1; cyc = 0;
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; pc = '0; redirect = 1'b0; mem_gnt = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0; inst_ready = 1'b0;
        redir_now = 1'b0; redir_tgt = '0; resp_cnt = 0; resp_addr = '0;
        en_knob = 1'b0; gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        pc_r = '0; cyc = 0; first_req = -1; val_cyc = -1;
        foreach (mem[i]) mem[i] = 8'($urandom);
        for (int b = 0; b < NB; b++) m_word[b] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // basic fetch at 0x000
        mem[12'h000] = 8'h34; mem[12'h001] = 8'h12;
        start_test(12'h000);
        run_until_valid(30);
        chk("t1_nreq", req_log.size(), 2);
        chk("t1_addr0", req_log[0], 12'h000);
        chk("t1_addr1", req_log[1], 12'h001);
        chk("t1_latency", val_cyc - first_req, 4);
        chk("t1_data", obs_data, 16'h1234);
        chk("t1_pc", obs_pc, 12'h000);
        chk("t1_adv", obs_adv, 1);
        cycle();
        chk("t1_adv_once", obs_adv, 0);

        // stalls on gnt and ready
        mem[12'h050] = 8'hCD; mem[12'h051] = 8'hAB;
        start_test(12'h050);
        gnt_pct = 0; rdy_pct = 0;
        cycle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t2_req_hold", obs_req, 1);
            chk("t2_addr_hold", obs_addr, 12'h050);
        end
        gnt_pct = 100;
        run_until_valid(30);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t2_valid_hold", obs_val, 1);
            chk("t2_data_hold", obs_data, 16'hABCD);
            chk("t2_no_adv", obs_adv, 0);
        end
        rdy_pct = 100;
        cycle();
        chk("t2_adv", obs_adv, 1);

        // address wrap
        mem[12'hFFF] = 8'h78; mem[12'h000] = 8'h56;
        start_test(12'hFFF);
        run_until_valid(30);
        chk("t3_addr0", req_log[0], 12'hFFF);
        chk("t3_addr1", req_log[1], 12'h000);
        chk("t3_pc", obs_pc, 12'hFFF);
        chk("t3_data", obs_data, 16'h5678);

        // redirect in WAIT before rvalid -> drain, late 0xAA discarded
        mem[12'h200] = 8'hAA; mem[12'h201] = 8'hBB;
        mem[12'h100] = 8'h11; mem[12'h101] = 8'h22;
        start_test(12'h200);
        lat_min = 3; lat_max = 3;
        cycle(); cycle(); cycle();
        redir_now = 1'b1; redir_tgt = 12'h100;
        lat_min = 1; lat_max = 1;
        req_log.delete(); first_req = -1;
        run_until_valid(30);
        chk("t4_addr", req_log[0], 12'h100);
        chk("t4_pc", obs_pc, 12'h100);
        chk("t4_data", obs_data, 16'h2211);

        // redirect together with inst_ready in DELIVER
        mem[12'h300] = 8'h9E; mem[12'h301] = 8'h5D;
        start_test(12'h040);
        rdy_pct = 0;
        run_until_valid(30);
        redir_now = 1'b1; redir_tgt = 12'h300; rdy_pct = 100;
        req_log.delete(); first_req = -1;
        cycle();
        chk("t5_valid", obs_val, 1);
        chk("t5_no_adv", obs_adv, 0);
        run_until_valid(30);
        chk("t5_addr", req_log[0], 12'h300);
        chk("t5_pc", obs_pc, 12'h300);
        chk("t5_data", obs_data, 16'h5D9E);

        // fetch_en dropped during byte 0
        start_test(12'h080);
        cycle();
        en_knob = 1'b0;
        run_until_valid(30);
        chk("t6_adv", obs_adv, 1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t6_idle_busy", obs_busy, 0);
            chk("t6_idle_req", obs_req, 0);
        end

        // reset during WAIT, stray rvalid afterwards
        en_knob = 1'b1; lat_min = 3; lat_max = 3;
        cycle(); cycle(); cycle();
        do_reset();
        en_knob = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("t6_stray_busy", obs_busy, 0);
        chk("t6_stray_valid", obs_val, 0);

        // randomized traffic
        pc_r = AW'($urandom);
        foreach (mem[i]) mem[i] = 8'($urandom);
        for (int blk = 0; blk < 20; blk++) begin
            if (blk == 10) do_reset();
            en_knob = ($urandom_range(9) != 0);
            gnt_pct = $urandom_range(100, 30);
            rdy_pct = $urandom_range(100, 20);
            lat_min = 1;
            lat_max = $urandom_range(4, 1);
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(99) < 4) begin
                    redir_now = 1'b1;
                    redir_tgt = AW'($urandom);
                end
                cycle();
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
